// File: rtl/ddr2_port_arbiter_0.sv
// ----------------------------------------------------------------------------
// ddr2_port_arbiter_0
//   Two-port round-robin arbiter/sequencer in front of the DDR2 user-interface
//   backend FIFOs. Ports P0/P1 share the address FIFO write port (app_af_*)
//   and the write-data FIFO write port (app_wdf_*). A write pushes
//   BURST_BEATS data beats first, then the address/command. All traffic is
//   gated on init_done and the FIFO almost-full flags at arbitration time.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   init_done                  memory init complete; no new grant while low
//   af_almost_full             address FIFO almost full
//   wdf_almost_full            write-data FIFO almost full
//   pN_req/pN_addr             N=0,1 command request, held until pN_gnt
//   pN_wdf_data/pN_mask_data   N=0,1 current write beat and mask
//   pN_wdf_rden                N=0,1 beat consumed this cycle
//   pN_gnt                     N=0,1 one-cycle pulse, pN_addr taken this cycle
//   app_af_*                   address FIFO write port (registered)
//   app_wdf_*/app_mask_data    write-data FIFO write port (registered)
//   busy                       sequencer not idle
// ----------------------------------------------------------------------------
module ddr2_port_arbiter_0 #(
    parameter int WDF_WIDTH   = 128,
    parameter int MASK_WIDTH  = 16,
    parameter int BURST_BEATS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init_done,
    input  logic                  af_almost_full,
    input  logic                  wdf_almost_full,
    input  logic                  p0_req,
    input  logic [35:0]           p0_addr,
    input  logic [WDF_WIDTH-1:0]  p0_wdf_data,
    input  logic [MASK_WIDTH-1:0] p0_mask_data,
    output logic                  p0_wdf_rden,
    output logic                  p0_gnt,
    input  logic                  p1_req,
    input  logic [35:0]           p1_addr,
    input  logic [WDF_WIDTH-1:0]  p1_wdf_data,
    input  logic [MASK_WIDTH-1:0] p1_mask_data,
    output logic                  p1_wdf_rden,
    output logic                  p1_gnt,
    output logic [35:0]           app_af_addr,
    output logic                  app_af_wren,
    output logic [WDF_WIDTH-1:0]  app_wdf_data,
    output logic [MASK_WIDTH-1:0] app_mask_data,
    output logic                  app_wdf_wren,
    output logic                  busy
);

    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] LAST_BEAT = 3'(BURST_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CMD  = 2'd2
    } state_t;

    state_t                state_q;
    logic                  sel_q;      // 0 = P0, 1 = P1
    logic                  rr_ptr_q;   // preferred port when both eligible
    logic [2:0]            beat_cnt_q;
    logic [35:0]           app_af_addr_q;
    logic                  app_af_wren_q;
    logic [WDF_WIDTH-1:0]  app_wdf_data_q;
    logic [MASK_WIDTH-1:0] app_mask_data_q;
    logic                  app_wdf_wren_q;

    // ------------------------------------------------------------------
    // Arbitration (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic wr0, wr1, elig0, elig1;
    logic sel_d, sel_is_wr_d;

    always_comb begin
        wr0   = (p0_addr[34:32] == CMD_WRITE);
        wr1   = (p1_addr[34:32] == CMD_WRITE);
        elig0 = p0_req & init_done & ~af_almost_full & (~wr0 | ~wdf_almost_full);
        elig1 = p1_req & init_done & ~af_almost_full & (~wr1 | ~wdf_almost_full);
        // Both eligible -> round-robin pointer; otherwise the lone eligible port.
        sel_d       = (elig0 & elig1) ? rr_ptr_q : elig1;
        sel_is_wr_d = sel_d ? wr1 : wr0;
    end

    // ------------------------------------------------------------------
    // Port strobes decoded from registered state only, so there is no
    // combinational path from any input to rden/gnt.
    // ------------------------------------------------------------------
    assign p0_wdf_rden = (state_q == DATA) & ~sel_q;
    assign p1_wdf_rden = (state_q == DATA) &  sel_q;
    assign p0_gnt      = (state_q == CMD)  & ~sel_q;
    assign p1_gnt      = (state_q == CMD)  &  sel_q;
    assign busy        = (state_q != IDLE);

    logic [35:0]           psel_addr;
    logic [WDF_WIDTH-1:0]  psel_data;
    logic [MASK_WIDTH-1:0] psel_mask;

    assign psel_addr = sel_q ? p1_addr      : p0_addr;
    assign psel_data = sel_q ? p1_wdf_data  : p0_wdf_data;
    assign psel_mask = sel_q ? p1_mask_data : p0_mask_data;

    // ------------------------------------------------------------------
    // Sequencer. The write/read decision is carried in the IDLE->DATA vs
    // IDLE->CMD transition, so no separate is_wr register is kept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            sel_q           <= 1'b0;
            rr_ptr_q        <= 1'b0;
            beat_cnt_q      <= 3'd0;
            app_af_addr_q   <= '0;
            app_af_wren_q   <= 1'b0;
            app_wdf_data_q  <= '0;
            app_mask_data_q <= '0;
            app_wdf_wren_q  <= 1'b0;
        end else begin
            app_af_wren_q  <= 1'b0;
            app_wdf_wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (elig0 | elig1) begin
                        sel_q   <= sel_d;
                        state_q <= sel_is_wr_d ? DATA : CMD;
                    end
                end
                DATA: begin
                    // A started burst runs to completion; the almost-full
                    // margin of the FIFO absorbs it.
                    app_wdf_data_q  <= psel_data;
                    app_mask_data_q <= psel_mask;
                    app_wdf_wren_q  <= 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_q <= 3'd0;
                        state_q    <= CMD;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 3'd1;
                    end
                end
                CMD: begin
                    app_af_addr_q <= psel_addr;
                    app_af_wren_q <= 1'b1;
                    rr_ptr_q      <= ~sel_q;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign app_af_addr   = app_af_addr_q;
    assign app_af_wren   = app_af_wren_q;
    assign app_wdf_data  = app_wdf_data_q;
    assign app_mask_data = app_mask_data_q;
    assign app_wdf_wren  = app_wdf_wren_q;

endmodule

// File: tb/tb_ddr2_port_arbiter_0.sv
// ----------------------------------------------------------------------------
// tb_ddr2_port_arbiter_0
//   Directed bench for ddr2_port_arbiter_0. Inputs are driven and outputs
//   sampled on the falling edge; "cycle k" below is the clock period after
//   the k-th rising edge following the cycle in which the request is seen.
// ----------------------------------------------------------------------------
module tb_ddr2_port_arbiter_0;

    localparam int WW = 128;
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_done, af_almost_full, wdf_almost_full;
    logic          p0_req, p1_req;
    logic [35:0]   p0_addr, p1_addr;
    logic [WW-1:0] p0_wdf_data, p1_wdf_data;
    logic [MW-1:0] p0_mask_data, p1_mask_data;
    logic          p0_wdf_rden, p1_wdf_rden, p0_gnt, p1_gnt;
    logic [35:0]   app_af_addr;
    logic          app_af_wren, app_wdf_wren, busy;
    logic [WW-1:0] app_wdf_data;
    logic [MW-1:0] app_mask_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr2_port_arbiter_0 #(.WDF_WIDTH(WW), .MASK_WIDTH(MW), .BURST_BEATS(2)) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .af_almost_full(af_almost_full), .wdf_almost_full(wdf_almost_full),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdf_data(p0_wdf_data),
        .p0_mask_data(p0_mask_data), .p0_wdf_rden(p0_wdf_rden), .p0_gnt(p0_gnt),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdf_data(p1_wdf_data),
        .p1_mask_data(p1_mask_data), .p1_wdf_rden(p1_wdf_rden), .p1_gnt(p1_gnt),
        .app_af_addr(app_af_addr), .app_af_wren(app_af_wren),
        .app_wdf_data(app_wdf_data), .app_mask_data(app_mask_data),
        .app_wdf_wren(app_wdf_wren), .busy(busy)
    );

    // Hard stop if something ever wedges the sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        init_done = 1'b1; af_almost_full = 1'b0; wdf_almost_full = 1'b0;
        p0_req = 1'b0; p1_req = 1'b0;
        p0_addr = '0; p1_addr = '0;
        p0_wdf_data = '0; p1_wdf_data = '0; p0_mask_data = '0; p1_mask_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({p0_wdf_rden, p1_wdf_rden, p0_gnt, p1_gnt, app_af_wren, app_wdf_wren, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b, required 0000000",
                     {p0_wdf_rden, p1_wdf_rden, p0_gnt, p1_gnt, app_af_wren, app_wdf_wren, busy});
        end
        checks++;
        if (app_af_addr !== 36'h0 || app_wdf_data !== '0 || app_mask_data !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h data=%h mask=%h, required all 0",
                     app_af_addr, app_wdf_data, app_mask_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // T1: P0 read
    task automatic test_read();
        p0_addr = 36'h5_0000_0040; p0_req = 1'b1;
        @(negedge clk);  // cycle 1
        checks++;
        if (p0_gnt !== 1'b1 || p0_wdf_rden !== 1'b0 || p1_gnt !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_gnt: gnt0=%b rden0=%b gnt1=%b busy=%b, required 1 0 0 1",
                     p0_gnt, p0_wdf_rden, p1_gnt, busy);
        end
        p0_req = 1'b0;
        @(negedge clk);  // cycle 2
        checks++;
        if (app_af_wren !== 1'b1 || app_af_addr !== 36'h5_0000_0040 || app_wdf_wren !== 1'b0) begin
            errors++;
            $display("FAIL read_af: wren=%b addr=%h wdf_wren=%b, required 1 500000040 0",
                     app_af_wren, app_af_addr, app_wdf_wren);
        end
        @(negedge clk);  // cycle 3
        checks++;
        if (app_af_wren !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: af_wren=%b busy=%b, required 0 0", app_af_wren, busy);
        end
    endtask

    // T2: P1 write with two beats
    task automatic test_write();
        logic [WW-1:0] a, b;
        a = {4{32'hAAAA_0001}}; b = {4{32'hBBBB_0002}};
        p1_addr = 36'h4_0000_0100; p1_wdf_data = a; p1_mask_data = 16'h00A1; p1_req = 1'b1;
        @(negedge clk);  // cycle 1
        checks++;
        if (p1_wdf_rden !== 1'b1 || p0_wdf_rden !== 1'b0 || p1_gnt !== 1'b0 || app_wdf_wren !== 1'b0) begin
            errors++;
            $display("FAIL write_c1: rden1=%b rden0=%b gnt1=%b wdf_wren=%b, required 1 0 0 0",
                     p1_wdf_rden, p0_wdf_rden, p1_gnt, app_wdf_wren);
        end
        @(negedge clk);  // cycle 2: beat A captured
        checks++;
        if (p1_wdf_rden !== 1'b1 || app_wdf_wren !== 1'b1 || app_wdf_data !== a || app_mask_data !== 16'h00A1) begin
            errors++;
            $display("FAIL write_c2: rden1=%b wren=%b data=%h mask=%h, required 1 1 %h 00a1",
                     p1_wdf_rden, app_wdf_wren, app_wdf_data, app_mask_data, a);
        end
        p1_wdf_data = b; p1_mask_data = 16'h00B2;
        @(negedge clk);  // cycle 3: beat B captured, grant
        checks++;
        if (app_wdf_wren !== 1'b1 || app_wdf_data !== b || app_mask_data !== 16'h00B2 ||
            p1_gnt !== 1'b1 || p1_wdf_rden !== 1'b0 || app_af_wren !== 1'b0) begin
            errors++;
            $display("FAIL write_c3: wren=%b data=%h mask=%h gnt1=%b rden1=%b af_wren=%b, required 1 %h 00b2 1 0 0",
                     app_wdf_wren, app_wdf_data, app_mask_data, p1_gnt, p1_wdf_rden, app_af_wren, b);
        end
        p1_req = 1'b0;
        @(negedge clk);  // cycle 4
        checks++;
        if (app_af_wren !== 1'b1 || app_af_addr !== 36'h4_0000_0100 || app_wdf_wren !== 1'b0 || app_wdf_data !== b) begin
            errors++;
            $display("FAIL write_c4: af_wren=%b addr=%h wdf_wren=%b data=%h, required 1 400000100 0 held",
                     app_af_wren, app_af_addr, app_wdf_wren, app_wdf_data);
        end
    endtask

    // T3: both ports read continuously -> strict alternation from P0
    task automatic test_back_to_back();
        logic [35:0] last_addr;
        int g;
        do_reset();
        p0_addr = 36'h0_0000_1000; p1_addr = 36'h1_0000_2000;
        p0_req = 1'b1; p1_req = 1'b1;
        last_addr = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                g = ((c - 1) / 2) % 2;
                checks++;
                if (p0_gnt !== (g == 0) || p1_gnt !== (g == 1)) begin
                    errors++;
                    $display("FAIL b2b_gnt c%0d: gnt0=%b gnt1=%b, required port %0d", c, p0_gnt, p1_gnt, g);
                end
                last_addr = (g == 0) ? 36'h0_0000_1000 : 36'h1_0000_2000;
                if (c == 11) begin p0_req = 1'b0; p1_req = 1'b0; end
            end else begin
                checks++;
                if (app_af_wren !== 1'b1 || app_af_addr !== last_addr || p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_af c%0d: wren=%b addr=%h gnts=%b%b, required 1 %h 00",
                             c, app_af_wren, app_af_addr, p0_gnt, p1_gnt, last_addr);
                end
            end
        end
    endtask

    // T4: af_almost_full and init_done block arbitration
    task automatic test_gating();
        p0_addr = 36'h0_0000_3000; p0_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) af_almost_full = 1'b1; else init_done = 1'b0;
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (p0_gnt !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL gate_block%0d: gnt0=%b busy=%b, required 0 0", k, p0_gnt, busy);
                end
            end
            af_almost_full = 1'b0; init_done = 1'b1;
            @(negedge clk);
            checks++;
            if (p0_gnt !== 1'b1) begin
                errors++;
                $display("FAIL gate_release%0d: gnt0=%b, required 1", k, p0_gnt);
            end
            if (k == 1) p0_req = 1'b0;
            @(negedge clk);
        end
    endtask

    // T5: P0 write blocked by wdf_almost_full, P1 read passes
    task automatic test_wdf_full();
        wdf_almost_full = 1'b1;
        p0_addr = 36'h4_0000_0200; p0_wdf_data = {4{32'hC0C0_0003}}; p0_req = 1'b1;
        p1_addr = 36'h0_0000_0300; p1_req = 1'b1;
        @(negedge clk);  // cycle 1
        checks++;
        if (p1_gnt !== 1'b1 || p0_wdf_rden !== 1'b0 || p0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL wdf_p1_first: gnt1=%b rden0=%b gnt0=%b, required 1 0 0", p1_gnt, p0_wdf_rden, p0_gnt);
        end
        p1_req = 1'b0;
        @(negedge clk);  // cycle 2: IDLE, P0 still blocked
        checks++;
        if (p0_wdf_rden !== 1'b0 || busy !== 1'b0 || app_af_addr !== 36'h0_0000_0300) begin
            errors++;
            $display("FAIL wdf_blocked: rden0=%b busy=%b addr=%h, required 0 0 000000300",
                     p0_wdf_rden, busy, app_af_addr);
        end
        wdf_almost_full = 1'b0;
        @(negedge clk);  // cycle 3
        checks++;
        if (p0_wdf_rden !== 1'b1) begin
            errors++;
            $display("FAIL wdf_release: rden0=%b, required 1", p0_wdf_rden);
        end
        repeat (2) @(negedge clk);  // cycle 5
        checks++;
        if (p0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL wdf_p0_gnt: gnt0=%b, required 1", p0_gnt);
        end
        p0_req = 1'b0;
        @(negedge clk);  // cycle 6
        checks++;
        if (app_af_wren !== 1'b1 || app_af_addr !== 36'h4_0000_0200) begin
            errors++;
            $display("FAIL wdf_p0_af: wren=%b addr=%h, required 1 400000200", app_af_wren, app_af_addr);
        end
    endtask

    // T6: reset in DATA after beat 0; rr_ptr was left pointing at P1
    task automatic test_reset_mid_burst();
        p0_addr = 36'h4_0000_0400; p0_wdf_data = {4{32'hD0D0_0004}}; p0_req = 1'b1;
        @(negedge clk);  // cycle 1: beat 0 rden
        @(negedge clk);  // cycle 2: beat 0 written, still in DATA
        checks++;
        if (app_wdf_wren !== 1'b1 || p0_wdf_rden !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: wdf_wren=%b rden0=%b, required 1 1", app_wdf_wren, p0_wdf_rden);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({p0_wdf_rden, p1_wdf_rden, p0_gnt, p1_gnt, app_af_wren, app_wdf_wren, busy} !== 7'b0 ||
            app_af_addr !== 36'h0 || app_wdf_data !== '0 || app_mask_data !== '0) begin
            errors++;
            $display("FAIL rst_mid: strobes=%b addr=%h data=%h mask=%h, required all 0",
                     {p0_wdf_rden, p1_wdf_rden, p0_gnt, p1_gnt, app_af_wren, app_wdf_wren, busy},
                     app_af_addr, app_wdf_data, app_mask_data);
        end
        reset = 1'b0; p0_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (app_af_wren !== 1'b0 || p0_gnt !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_abort: af_wren=%b gnt0=%b busy=%b, required 0 0 0", app_af_wren, p0_gnt, busy);
            end
        end
        // rr_ptr back at P0: contention must go to P0 first
        p0_addr = 36'h0_0000_0500; p1_addr = 36'h0_0000_0600;
        p0_req = 1'b1; p1_req = 1'b1;
        @(negedge clk);
        checks++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_rrptr: gnt0=%b gnt1=%b, required 1 0", p0_gnt, p1_gnt);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_gating();
        test_wdf_full();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
